// File: rtl/uart_tx_serializer.sv
// UART-style transmitter: takes a parallel word over valid/ready and shifts out
// start, data (LSB first), optional parity and stop bits at a fixed baud divider.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_MAX = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        div;
    logic [BW-1:0]        bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 boundary;

    assign boundary = (div == CNT_MAX);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    div    <= '0;
                    bitcnt <= '0;
                    tx     <= 1'b1;
                    if (in_valid) begin
                        // parity is frozen from the captured word, not live input
                        shreg   <= in_data;
                        par_bit <= (^in_data) ^ (PARITY == 2);
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (boundary) begin
                        div   <= '0;
                        tx    <= shreg[0];
                        state <= DATA;
                    end else begin
                        div <= div + CW'(1);
                    end
                end
                DATA: begin
                    if (boundary) begin
                        div <= '0;
                        if (bitcnt == BIT_MAX) begin
                            bitcnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            shreg  <= shreg >> 1;
                            tx     <= shreg[1];
                        end
                    end else begin
                        div <= div + CW'(1);
                    end
                end
                PAR: begin
                    if (boundary) begin
                        div   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        div <= div + CW'(1);
                    end
                end
                STOP: begin
                    if (boundary) begin
                        div <= '0;
                        if (bitcnt == STOP_MAX) begin
                            bitcnt <= '0;
                            state  <= IDLE;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                        end
                    end else begin
                        div <= div + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    div   <= '0;
                end
            endcase
        end
    end
endmodule
